ttt_dot_render: RTL and testbench

TTT_DOT_RENDER -- requirements
Module: ttt_dot_render

---
 rtl/ttt_pkg.sv | 40 ++++
 rtl/ttt_dot_render_if.sv | 22 ++
 rtl/ttt_tick_gen.sv | 34 +++
 rtl/ttt_dot_render.sv | 135 +++++++++++++
 tb/tb_ttt_dot_render.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/ttt_pkg.sv
// Shared definitions for the tic-tac-toe dot-matrix renderer: cell codes,
// matrix geometry and glyph bitmaps.
package ttt_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    X     = 2'b01,
    O     = 2'b10
  } cell_e;

  localparam int unsigned CELLS      = 9;
  localparam int unsigned ROWS       = 10;
  localparam int unsigned COLS       = 14;
  localparam int unsigned CELL_W     = 4;
  localparam int unsigned CELL_H     = 3;
  localparam int unsigned GRID       = 3;
  localparam int unsigned CELL_PITCH = CELL_W + 1;
  localparam int unsigned STATUS_ROW = ROWS - 1;

  // Glyph lines indexed by line-within-cell; bit 0 is the leftmost dot.
  localparam logic [CELL_H-1:0][CELL_W-1:0] X_GLYPH = {4'b1001, 4'b0110, 4'b1001};
  localparam logic [CELL_H-1:0][CELL_W-1:0] O_GLYPH = {4'b1111, 4'b1001, 4'b1111};

  localparam logic [COLS-1:0] TURN_X_COLS = 14'h000F;
  localparam logic [COLS-1:0] TURN_O_COLS = 14'h3C00;

  // Code 2'b11 is not a legal mark and falls through to a blank cell.
  function automatic logic [CELL_W-1:0] glyph_line(input logic [1:0] code,
                                                    input logic [1:0] line);
    logic [CELL_W-1:0] g;
    g = '0;
    case (code)
      X:       g = X_GLYPH[line];
      O:       g = O_GLYPH[line];
      default: g = '0;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/ttt_dot_render_if.sv
// Game-state inputs and matrix drive outputs of the dot renderer.
interface ttt_dot_render_if;
  import ttt_pkg::*;

  logic                 en;
  logic [2*CELLS-1:0]   board;
  logic [3:0]           cursor;
  logic                 turn_o;
  logic [ROWS-1:0]      dot_row;
  logic [COLS-1:0]      dot_col;

  modport slave (
    input  en, board, cursor, turn_o,
    output dot_row, dot_col
  );

  modport master (
    output en, board, cursor, turn_o,
    input  dot_row, dot_col
  );

endinterface

// File: rtl/ttt_tick_gen.sv
// Free-running prescaler: one-cycle tick every DIV enabled clocks.
module ttt_tick_gen #(
  parameter int unsigned DIV = 12500
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = en && (cnt_q == TERM);
    cnt_d = cnt_q;
    if (!en || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ttt_dot_render.sv
// Row-scanned 10x14 dot-matrix renderer for a 3x3 tic-tac-toe board with
// blinking cursor and a turn indicator on the bottom row.
module ttt_dot_render
  import ttt_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 12500,
  parameter int unsigned BLINK_FRAMES = 16
) (
  input  logic            clk,
  input  logic            rst,
  ttt_dot_render_if.slave bus
);

  localparam int unsigned RW = $clog2(ROWS);
  localparam int unsigned BW = $clog2(BLINK_FRAMES + 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(STATUS_ROW);
  localparam logic [BW-1:0] BLINK_TOP = BW'(BLINK_FRAMES);

  logic                tick;
  logic                frame_start;

  logic [RW-1:0]       row_q, row_d;
  logic [BW-1:0]       blink_cnt_q, blink_cnt_d;
  logic                blink_q, blink_d;
  logic [2*CELLS-1:0]  board_q, board_d;
  logic [3:0]          cursor_q, cursor_d;
  logic                turn_q, turn_d;
  logic [ROWS-1:0]     dot_row_q, dot_row_d;
  logic [COLS-1:0]     dot_col_q, dot_col_d;
  logic [COLS-1:0]     pattern;

  logic                cur_valid;
  int unsigned         cur_k;
  int unsigned         cell_r;
  int unsigned         line;
  int unsigned         k;
  logic [CELL_W-1:0]   g;

  ttt_tick_gen #(
    .DIV (SCAN_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (bus.en),
    .tick (tick)
  );

  assign frame_start = tick && (row_q == LAST_ROW);

  // Next-state: snapshot and blink phase are taken from their _d values so the
  // frame-start row already renders from the freshly latched state.
  always_comb begin
    row_d       = row_q;
    blink_cnt_d = blink_cnt_q;
    blink_d     = blink_q;
    board_d     = board_q;
    cursor_d    = cursor_q;
    turn_d      = turn_q;
    dot_row_d   = dot_row_q;
    dot_col_d   = dot_col_q;

    if (!bus.en) begin
      row_d       = LAST_ROW;
      blink_cnt_d = '0;
      blink_d     = 1'b0;
      dot_row_d   = '0;
      dot_col_d   = '0;
    end else if (tick) begin
      row_d = (row_q == LAST_ROW) ? '0 : row_q + 1'b1;
      if (frame_start) begin
        board_d  = bus.board;
        cursor_d = bus.cursor;
        turn_d   = bus.turn_o;
        // Counter starts at 0 but wraps to 1, so the first phase spans
        // exactly BLINK_FRAMES frames just like every later one.
        if (blink_cnt_q == BLINK_TOP) begin
          blink_cnt_d = BW'(1);
          blink_d     = ~blink_q;
        end else begin
          blink_cnt_d = blink_cnt_q + 1'b1;
        end
      end
      dot_row_d = ROWS'(1) << row_d;
      dot_col_d = pattern;
    end
  end

  always_comb begin
    pattern   = '0;
    g         = '0;
    k         = 0;
    cur_valid = (cursor_d != 4'd0) && (cursor_d <= 4'(CELLS));
    cur_k     = 32'(cursor_d) - 1;
    cell_r    = 32'(row_d) / CELL_H;
    line      = 32'(row_d) % CELL_H;
    if (row_d == LAST_ROW) begin
      pattern = turn_d ? TURN_O_COLS : TURN_X_COLS;
    end else begin
      for (int unsigned c = 0; c < GRID; c++) begin
        k = cell_r * GRID + c;
        g = (k < CELLS) ? glyph_line(board_d[2*k +: 2], 2'(line)) : '0;
        if (blink_d && cur_valid && (k == cur_k)) begin
          g = ~g;
        end
        pattern[c*CELL_PITCH +: CELL_W] = g;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_q       <= LAST_ROW;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      board_q     <= '0;
      cursor_q    <= '0;
      turn_q      <= 1'b0;
      dot_row_q   <= '0;
      dot_col_q   <= '0;
    end else begin
      row_q       <= row_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      board_q     <= board_d;
      cursor_q    <= cursor_d;
      turn_q      <= turn_d;
      dot_row_q   <= dot_row_d;
      dot_col_q   <= dot_col_d;
    end
  end

  assign bus.dot_row = dot_row_q;
  assign bus.dot_col = dot_col_q;

endmodule

// File: tb/tb_ttt_dot_render.sv
// Bench for ttt_dot_render: cycle-level reference model plus directed checks.
module tb_ttt_dot_render;

  localparam int DIV = 4;
  localparam int BF  = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;

  ttt_dot_render_if bus ();

  ttt_dot_render #(
    .SCAN_DIV     (DIV),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [9:0]  exp_row = '0;
  logic [13:0] exp_col = '0;
  int          run = 0;
  int          mj, mr, mf;
  logic [17:0] snap_b = '0;
  logic [3:0]  snap_c = '0;
  logic        snap_t = 1'b0;

  // Dot pattern of one matrix row, derived dot by dot from the screen layout.
  function automatic logic [13:0] render(input logic [17:0] b, input logic [3:0] cur,
                                         input logic t, input int blink, input int row);
    logic [13:0] res;
    int pos, kk, ln, code;
    logic on;
    res = '0;
    if (row == 9) return t ? 14'h3C00 : 14'h000F;
    ln = row % 3;
    for (int c = 0; c < 14; c++) begin
      pos = c % 5;
      if (pos != 4) begin
        kk   = 3 * (row / 3) + c / 5;
        code = int'((b >> (2 * kk)) & 18'h3);
        on   = 1'b0;
        if (code == 1) on = (ln == 1) ? (pos == 1 || pos == 2) : (pos == 0 || pos == 3);
        else if (code == 2) on = (ln == 1) ? (pos == 0 || pos == 3) : 1'b1;
        if (blink != 0 && cur >= 1 && cur <= 9 && kk == int'(cur) - 1) on = ~on;
        res[c] = on;
      end
    end
    return res;
  endfunction

  // Timeline model: tick j lands DIV enabled cycles apart; row = j%10,
  // frame = j/10, blink phase = (frame/BF)%2.
  always @(posedge clk) begin
    if (!rst || !bus.en) begin
      run     = 0;
      exp_row = '0;
      exp_col = '0;
    end else begin
      if (run % DIV == DIV - 1) begin
        mj = run / DIV;
        mr = mj % 10;
        mf = mj / 10;
        if (mr == 0) begin
          snap_b = bus.board;
          snap_c = bus.cursor;
          snap_t = bus.turn_o;
        end
        exp_row = 10'(1) << mr;
        exp_col = render(snap_b, snap_c, snap_t, (mf / BF) % 2, mr);
      end
      run++;
    end
  end

  always @(negedge rst) begin
    run     = 0;
    exp_row = '0;
    exp_col = '0;
  end

  always @(negedge clk) begin
    checks++;
    if (bus.dot_row !== exp_row || bus.dot_col !== exp_col) begin
      failures++;
      $display("FAIL model t=%0t: got row=0x%0h col=0x%0h want row=0x%0h col=0x%0h",
               $time, bus.dot_row, bus.dot_col, exp_row, exp_col);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, expv);
    end
  endtask

  // Returns at the first negedge of the next occurrence of row r.
  task automatic wait_row(input int r);
    logic [9:0] target;
    int n;
    target = 10'(1) << r;
    n = 0;
    @(negedge clk);
    while (bus.dot_row == target && n < 60) begin @(negedge clk); n++; end
    while (bus.dot_row != target && n < 60) begin @(negedge clk); n++; end
    if (bus.dot_row != target) begin
      checks++;
      failures++;
      $display("FAIL wait_row%0d timeout: got 0x%0h want 0x%0h", r, bus.dot_row, target);
    end
  endtask

  initial begin
    bus.en     = 1'b0;
    bus.board  = '0;
    bus.cursor = '0;
    bus.turn_o = 1'b0;

    // Model pinned against hand-derived rows
    check("model_x_line1", 32'(render(18'h00001, 4'd0, 1'b0, 0, 1)), 32'h6);
    check("model_o_line0", 32'(render(18'h00200, 4'd0, 1'b0, 0, 3)), 32'h1E0);
    check("model_blink_c9", 32'(render(18'h0, 4'd9, 1'b0, 1, 7)), 32'h3C00);
    check("model_11_inv", 32'(render(18'h3FFFF, 4'd5, 1'b0, 1, 4)), 32'h1E0);

    #1;
    check("reset_row", 32'(bus.dot_row), 32'h0);
    check("reset_col", 32'(bus.dot_col), 32'h0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1; bus.en = 1'b1;

    // Blank board: only the X-to-move indicator on row 9
    wait_row(0); check("blank_r0", 32'(bus.dot_col), 32'h0);
    wait_row(9); check("blank_r9", 32'(bus.dot_col), 32'h000F);

    // Cell 0 = X, cell 4 = O; bit 9 is a gap column, so the O top line is 0x1E0
    @(posedge clk); #2 bus.board = 18'h00201;
    wait_row(0); check("xo_r0", 32'(bus.dot_col), 32'h9);
    wait_row(1); check("xo_r1", 32'(bus.dot_col), 32'h6);
    wait_row(2); check("xo_r2", 32'(bus.dot_col), 32'h9);
    wait_row(3); check("xo_r3", 32'(bus.dot_col), 32'h1E0);
    wait_row(4); check("xo_r4", 32'(bus.dot_col), 32'h120);

    // Mid-frame board change stays invisible until the next frame
    @(posedge clk); #2 bus.board = 18'h02000;
    wait_row(5); check("tear_r5_old", 32'(bus.dot_col), 32'h1E0);
    wait_row(6); check("tear_r6_old", 32'(bus.dot_col), 32'h0);
    wait_row(0); check("tear_r0_new", 32'(bus.dot_col), 32'h0);
    wait_row(6); check("tear_r6_new", 32'(bus.dot_col), 32'h00F);

    @(posedge clk); #2 bus.turn_o = 1'b1;
    wait_row(9); check("turn_old", 32'(bus.dot_col), 32'h000F);
    wait_row(9); check("turn_new", 32'(bus.dot_col), 32'h3C00);

    // Asynchronous reset mid-row, then restart timing
    @(posedge clk); #2 rst = 1'b0;
    #1;
    check("async_rst_row", 32'(bus.dot_row), 32'h0);
    check("async_rst_col", 32'(bus.dot_col), 32'h0);
    bus.board = '0; bus.cursor = 4'd9; bus.turn_o = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_rel_3clk", 32'(bus.dot_row), 32'h0);
    @(negedge clk);
    check("rst_rel_4clk", 32'(bus.dot_row), 32'h001);
    check("rst_rel_col", 32'(bus.dot_col), 32'h0);

    // Cursor on cell 9 blinks: frames 2..3 on, 0..1 and 4..5 off
    for (int f = 0; f < 6; f++) begin
      wait_row(6);
      check($sformatf("blink_f%0d", f), 32'(bus.dot_col), ((f / 2) % 2 != 0) ? 32'h3C00 : 32'h0);
    end

    // Drop enable at row 6, restart with all-11 board
    @(posedge clk); #2 bus.en = 1'b0;
    @(posedge clk); @(negedge clk);
    check("en_off_row", 32'(bus.dot_row), 32'h0);
    check("en_off_col", 32'(bus.dot_col), 32'h0);
    bus.board = 18'h3FFFF;
    repeat (3) @(posedge clk);
    #2 bus.en = 1'b1;
    repeat (4) @(negedge clk);
    check("en_on_3clk", 32'(bus.dot_row), 32'h0);
    @(negedge clk);
    check("en_on_row0", 32'(bus.dot_row), 32'h001);
    check("all11_r0", 32'(bus.dot_col), 32'h0);
    wait_row(4); check("all11_r4", 32'(bus.dot_col), 32'h0);
    wait_row(9); check("all11_r9", 32'(bus.dot_col), 32'h000F);
    wait_row(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

endmodule
